// File: rtl/color_sensor_emulator_pkg.sv
// Shared color/filter codes, FSM state encoding and the filter match rule
// for the color-sensor emulator.
package color_sensor_emulator_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] BLUE   = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

    // Filter codes are the raw S2,S3 pin pair, not the color encoding.
    localparam logic [1:0] F_RED   = 2'b00;
    localparam logic [1:0] F_BLUE  = 2'b01;
    localparam logic [1:0] F_CLEAR = 2'b10;
    localparam logic [1:0] F_GREEN = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE   = 2'd1,
        RUN_HIGH = 2'd2,
        RUN_LOW  = 2'd3
    } state_t;

    // Yellow reflects both red and green light, so it reads strong on either filter.
    function automatic logic symbol_matches(input logic [1:0] symbol, input logic [1:0] filter);
        logic match;
        case (filter)
            F_RED:   match = (symbol == RED) || (symbol == YELLOW);
            F_GREEN: match = (symbol == GREEN) || (symbol == YELLOW);
            F_BLUE:  match = (symbol == BLUE);
            default: match = 1'b0;
        endcase
        return match;
    endfunction

endpackage

// File: rtl/color_sensor_emulator_symbol_table.sv
// 16-entry table of programmed color symbols: synchronous write,
// combinational read, cleared to red on reset.
module color_sensor_emulator_symbol_table
    import color_sensor_emulator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       write_en,
    input  logic [3:0] write_index,
    input  logic [1:0] write_color,
    input  logic [3:0] read_index,
    output logic [1:0] read_color
);

    logic [1:0] mem [16];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= RED;
            end
        end else if (write_en) begin
            mem[write_index] <= write_color;
        end
    end

    assign read_color = mem[read_index];

endmodule

// File: rtl/color_sensor_emulator.sv
// Emulates a color-sensor bank: square wave whose half-period encodes how
// strongly the selected sensor's symbol responds to the selected filter.
module color_sensor_emulator
    import color_sensor_emulator_pkg::*;
#(
    parameter int STRONG_HALF   = 10,
    parameter int WEAK_HALF     = 40,
    parameter int CLEAR_HALF    = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int HW            = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] sensorSelect,
    input  logic [1:0] colorSelect,
    input  logic       loadValid,
    input  logic [3:0] loadIndex,
    input  logic [1:0] loadColor,
    output logic       frequency,
    output logic       running
);

    localparam logic [HW-1:0] SETTLE_LOAD = HW'(SETTLE_CYCLES - 1);

    state_t        state, state_next;
    logic [HW-1:0] count, count_next;
    logic [5:0]    sel_q;
    logic          sel_changed;
    logic [1:0]    symbol;

    color_sensor_emulator_symbol_table u_table (
        .clk         (clk),
        .reset       (reset),
        .write_en    (loadValid),
        .write_index (loadIndex),
        .write_color (loadColor),
        .read_index  (sensorSelect),
        .read_color  (symbol)
    );

    assign sel_changed = ({sensorSelect, colorSelect} != sel_q);

    // Returns H-1 so the counter can be loaded directly; H of 0 is promoted to 1.
    function automatic logic [HW-1:0] half_load(input logic [1:0] sym, input logic [1:0] filt);
        logic [HW-1:0] h;
        if (filt == F_CLEAR) begin
            h = HW'(CLEAR_HALF);
        end else if (symbol_matches(sym, filt)) begin
            h = HW'(STRONG_HALF);
        end else begin
            h = HW'(WEAK_HALF);
        end
        if (h == '0) begin
            h = HW'(1);
        end
        return h - HW'(1);
    endfunction

    always_comb begin
        state_next = state;
        count_next = count;
        if (!enable) begin
            state_next = IDLE;
            count_next = '0;
        end else if (state == IDLE) begin
            state_next = SETTLE;
            count_next = SETTLE_LOAD;
        end else if (sel_changed) begin
            state_next = SETTLE;
            count_next = SETTLE_LOAD;
        end else if (count == '0) begin
            // Half length is sampled only here, so a table load never stretches a half already in progress.
            state_next = (state == RUN_HIGH) ? RUN_LOW : RUN_HIGH;
            count_next = half_load(symbol, colorSelect);
        end else begin
            count_next = count - HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            sel_q     <= '0;
            frequency <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            sel_q     <= {sensorSelect, colorSelect};
            frequency <= (state_next == RUN_HIGH);
            running   <= (state_next == RUN_HIGH) || (state_next == RUN_LOW);
        end
    end

endmodule
